// File: rtl/cpu_bus_serdes.sv
// cpu_bus_serdes: serialises CPU accesses into address, command and data lane beats.
// Define CPU_BUS_SERDES_WAIT_EN to let ext_wait stall WDATA/RDATA beats.
module cpu_bus_serdes #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LANE_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              busy,
    output logic [LANE_W-1:0] bus_out,
    output logic              bus_strobe,
    output logic [LANE_W-1:0] io_out,
    input  logic [LANE_W-1:0] io_in,
    output logic [LANE_W-1:0] io_oe,
    input  logic              ext_wait
);
    localparam int ADDR_BEATS = ADDR_W / LANE_W;
    localparam int DATA_BEATS = DATA_W / LANE_W;
    localparam int MAX_BEATS  = ADDR_BEATS > DATA_BEATS ? ADDR_BEATS : DATA_BEATS;
    localparam int CNT_W      = MAX_BEATS > 1 ? $clog2(MAX_BEATS) : 1;

    if (ADDR_W % LANE_W != 0 || DATA_W % LANE_W != 0) begin : g_bad_width
        $error("cpu_bus_serdes: ADDR_W and DATA_W must be multiples of LANE_W");
    end

    typedef enum logic [2:0] {IDLE, ADDR, CMD, WDATA, TURN, RDATA, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   beat_q, beat_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  shadow_q, shadow_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic [LANE_W-1:0]  bus_out_q, bus_out_d;
    logic               strobe_q, strobe_d;
    logic [LANE_W-1:0]  io_out_q, io_out_d;
    logic [LANE_W-1:0]  io_oe_q, io_oe_d;
    logic               stall;

`ifdef CPU_BUS_SERDES_WAIT_EN
    assign stall = ext_wait && (state_q == WDATA || state_q == RDATA);
`else
    logic unused_ext_wait;
    assign unused_ext_wait = ext_wait;
    assign stall = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        shadow_d = shadow_q;
        rdata_d  = rdata_q;
        case (state_q)
            IDLE: if (cpu_req) begin
                we_d    = cpu_we;
                addr_d  = cpu_addr;
                wdata_d = cpu_wdata;
                state_d = ADDR;
            end
            ADDR: if (beat_q == CNT_W'(ADDR_BEATS - 1)) state_d = CMD;
                  else beat_d = beat_q + 1'b1;
            CMD:  state_d = we_q ? WDATA : TURN;
            WDATA: if (!stall) begin
                if (beat_q == CNT_W'(DATA_BEATS - 1)) state_d = DONE;
                else beat_d = beat_q + 1'b1;
            end
            TURN: state_d = RDATA;
            RDATA: if (!stall) begin
                shadow_d[beat_q*LANE_W +: LANE_W] = io_in;
                if (beat_q == CNT_W'(DATA_BEATS - 1)) begin
                    state_d = DONE;
                    rdata_d = shadow_d;
                end else beat_d = beat_q + 1'b1;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) beat_d = '0;
        // Outputs are registered from the next state so they line up with it
        bus_out_d = state_d == ADDR ? addr_d[beat_d*LANE_W +: LANE_W]
                  : state_d == CMD  ? LANE_W'(we_d) : '0;
        strobe_d  = state_d == ADDR || state_d == CMD || state_d == WDATA || state_d == RDATA;
        io_out_d  = state_d == WDATA ? wdata_d[beat_d*LANE_W +: LANE_W] : '0;
        io_oe_d   = {LANE_W{state_d == WDATA}};
        ready_d   = state_d == DONE;
        busy_d    = state_d != IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            shadow_q  <= '0;
            rdata_q   <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            bus_out_q <= '0;
            strobe_q  <= 1'b0;
            io_out_q  <= '0;
            io_oe_q   <= '0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            shadow_q  <= shadow_d;
            rdata_q   <= rdata_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            bus_out_q <= bus_out_d;
            strobe_q  <= strobe_d;
            io_out_q  <= io_out_d;
            io_oe_q   <= io_oe_d;
        end
    end

    assign cpu_rdata  = rdata_q;
    assign cpu_ready  = ready_q;
    assign busy       = busy_q;
    assign bus_out    = bus_out_q;
    assign bus_strobe = strobe_q;
    assign io_out     = io_out_q;
    assign io_oe      = io_oe_q;
endmodule

// File: tb/tb_cpu_bus_serdes.sv
// tb_cpu_bus_serdes: randomized and directed checks of cpu_bus_serdes against a cycle-trace model.
module tb_cpu_bus_serdes;
    logic        clk = 0, rst_n = 1;
    logic        cpu_req = 0, cpu_we = 0, ext_wait = 0;
    logic [31:0] cpu_addr = 0, cpu_wdata = 0;
    logic [31:0] cpu_rdata;
    logic        cpu_ready, busy, bus_strobe;
    logic [7:0]  bus_out, io_out, io_oe;
    logic [7:0]  io_in = 0;

    logic        req2 = 0;
    logic [15:0] addr2 = 0;
    logic [31:0] wdata2 = 0, rdata2;
    logic        ready2, busy2, strobe2;
    logic [15:0] bus_out2, unused_io_out2, io_oe2;
    logic [15:0] io_in2 = 0;

    int checks = 0, errors = 0;
    logic [31:0] exp_rdata = 0;
    bit w [64];

    typedef struct {
        logic [7:0] bus;
        logic       strobe;
        logic [7:0] io;
        logic [7:0] oe;
        logic       ready;
        bit         cap;
        int         lane;
    } ent_t;
    ent_t tr [$];

    always #5 clk = ~clk;

    cpu_bus_serdes dut (
        .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .busy(busy),
        .bus_out(bus_out), .bus_strobe(bus_strobe), .io_out(io_out), .io_in(io_in),
        .io_oe(io_oe), .ext_wait(ext_wait)
    );

    cpu_bus_serdes #(.ADDR_W(16), .DATA_W(32), .LANE_W(16)) dut2 (
        .clk(clk), .rst_n(rst_n), .cpu_req(req2), .cpu_we(1'b0), .cpu_addr(addr2),
        .cpu_wdata(wdata2), .cpu_rdata(rdata2), .cpu_ready(ready2), .busy(busy2),
        .bus_out(bus_out2), .bus_strobe(strobe2), .io_out(unused_io_out2), .io_in(io_in2),
        .io_oe(io_oe2), .ext_wait(1'b0)
    );

    function automatic ent_t mk(logic [7:0] bus, logic stb, logic [7:0] io, logic [7:0] oe,
                                logic rdy, bit cap, int lane);
        ent_t e;
        e.bus = bus; e.strobe = stb; e.io = io; e.oe = oe; e.ready = rdy; e.cap = cap; e.lane = lane;
        return e;
    endfunction

    // Expected per-cycle outputs after acceptance; index i is cycle i+1, w[] is indexed by cycle
    function automatic void build(bit we, logic [31:0] addr, logic [31:0] wdata);
        int c;
        tr.delete();
        for (int i = 0; i < 4; i++) tr.push_back(mk(addr[8*i +: 8], 1, 0, 0, 0, 0, 0));
        tr.push_back(mk({7'b0, we}, 1, 0, 0, 0, 0, 0));
        c = 6;
        if (!we) begin
            tr.push_back(mk(0, 0, 0, 0, 0, 0, 0));
            c = 7;
        end
        for (int b = 0; b < 4; b++) begin
`ifdef CPU_BUS_SERDES_WAIT_EN
            while (c < 64 && w[c]) begin
                tr.push_back(we ? mk(0, 1, wdata[8*b +: 8], 8'hFF, 0, 0, b) : mk(0, 1, 0, 0, 0, 0, b));
                c++;
            end
`endif
            tr.push_back(we ? mk(0, 1, wdata[8*b +: 8], 8'hFF, 0, 0, b) : mk(0, 1, 0, 0, 0, 1, b));
            c++;
        end
        tr.push_back(mk(0, 0, 0, 0, 1, 0, 0));
    endfunction

    task automatic run_access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                              input bit hold, input bit fixed, input logic [31:0] fixed_rd,
                              output int rdy_cycle);
        logic [31:0] got = '0;
        ent_t e;
        build(we, addr, wdata);
        cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        rdy_cycle = -1;
        for (int i = 0; i < tr.size(); i++) begin
            @(posedge clk); #1;
            if (!hold) cpu_req = 0;
            e = tr[i];
            checks++;
            if (busy !== 1'b1 || bus_out !== e.bus || bus_strobe !== e.strobe || io_oe !== e.oe ||
                cpu_ready !== e.ready || (e.oe == 8'hFF && io_out !== e.io)) begin
                errors++;
                $display("FAIL trace cyc%0d: got busy=%b bus=%h stb=%b io=%h oe=%h rdy=%b, want bus=%h stb=%b io=%h oe=%h rdy=%b",
                         i + 1, busy, bus_out, bus_strobe, io_out, io_oe, cpu_ready,
                         e.bus, e.strobe, e.io, e.oe, e.ready);
            end
            if (cpu_ready === 1'b1 && rdy_cycle < 0) rdy_cycle = i + 1;
            if (e.ready) begin
                if (!we) exp_rdata = got;
                checks++;
                if (cpu_rdata !== exp_rdata) begin
                    errors++;
                    $display("FAIL rdata: got %h want %h", cpu_rdata, exp_rdata);
                end
            end
            ext_wait = w[i + 1];
            io_in = (e.cap && fixed) ? fixed_rd[8*e.lane +: 8] : 8'($urandom);
            if (e.cap) got[8*e.lane +: 8] = io_in;
        end
        @(posedge clk); #1;
        ext_wait = 0;
        checks++;
        if (busy !== 1'b0 || cpu_ready !== 1'b0 || cpu_rdata !== exp_rdata) begin
            errors++;
            $display("FAIL idle: got busy=%b rdy=%b rdata=%h want 0 0 %h", busy, cpu_ready, cpu_rdata, exp_rdata);
        end
    endtask

    task automatic test_reset;
        #2 rst_n = 0;
        #1;
        checks++;
        if ({cpu_rdata, cpu_ready, busy, bus_out, bus_strobe, io_out, io_oe} !== '0) begin
            errors++;
            $display("FAIL reset: got rdata=%h rdy=%b busy=%b bus=%h stb=%b io=%h oe=%h want all 0",
                     cpu_rdata, cpu_ready, busy, bus_out, bus_strobe, io_out, io_oe);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || busy2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b busy2=%b want 0 0", busy, busy2);
        end
    endtask

    task automatic test_write;
        int rc;
        run_access(1, 32'h12345678, 32'hCAFEBABE, 0, 0, 0, rc);
        checks++;
        if (rc != 10) begin
            errors++;
            $display("FAIL write_latency: got %0d want 10", rc);
        end
    endtask

    task automatic test_read;
        int rc;
        run_access(0, 32'h000000A5, 0, 0, 1, 32'h44332211, rc);
        checks++;
        if (rc != 11 || cpu_rdata !== 32'h44332211) begin
            errors++;
            $display("FAIL read: got latency %0d rdata %h want 11 44332211", rc, cpu_rdata);
        end
    endtask

    task automatic test_back_to_back;
        int rc;
        run_access(1, $urandom, $urandom, 1, 0, 0, rc);
        run_access(0, $urandom, 0, 0, 0, 0, rc);
        checks++;
        if (rc != 11) begin
            errors++;
            $display("FAIL b2b_latency: got %0d want 11", rc);
        end
    endtask

    task automatic test_wait;
        int rc, want;
`ifdef CPU_BUS_SERDES_WAIT_EN
        want = 14;
`else
        want = 11;
`endif
        w[8] = 1; w[9] = 1; w[10] = 1;
        run_access(0, 32'h000000A5, 0, 0, 1, 32'h44332211, rc);
        w = '{default: 0};
        checks++;
        if (rc != want || cpu_rdata !== 32'h44332211) begin
            errors++;
            $display("FAIL wait: got latency %0d rdata %h want %0d 44332211", rc, cpu_rdata, want);
        end
    endtask

    task automatic test_random;
        int rc;
        for (int n = 0; n < 20; n++) begin
            w = '{default: 0};
            for (int k = $urandom_range(0, 3); k > 0; k--) w[$urandom_range(6, 14)] = 1;
            run_access(1'($urandom), $urandom, $urandom, 0, 0, 0, rc);
        end
        w = '{default: 0};
    endtask

    task automatic test_reset_mid_write;
        int rc;
        cpu_req = 1; cpu_we = 1; cpu_addr = $urandom; cpu_wdata = $urandom;
        for (int i = 1; i <= 7; i++) begin
            @(posedge clk); #1;
            cpu_req = 0;
        end
        checks++;
        if (io_oe !== 8'hFF || bus_strobe !== 1'b1 || io_out !== cpu_wdata[15:8]) begin
            errors++;
            $display("FAIL mid_write_beat: got oe=%h stb=%b io=%h want FF 1 %h", io_oe, bus_strobe, io_out, cpu_wdata[15:8]);
        end
        #2 rst_n = 0;
        #1;
        exp_rdata = 0;
        checks++;
        if (io_oe !== 8'h00 || busy !== 1'b0 || bus_strobe !== 1'b0 || io_out !== 8'h00 ||
            cpu_ready !== 1'b0 || cpu_rdata !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: got oe=%h busy=%b stb=%b io=%h rdy=%b rdata=%h want all 0",
                     io_oe, busy, bus_strobe, io_out, cpu_ready, cpu_rdata);
        end
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;
        run_access(0, $urandom, 0, 0, 0, 0, rc);
        checks++;
        if (rc != 11) begin
            errors++;
            $display("FAIL post_reset_read: got latency %0d want 11", rc);
        end
    endtask

    task automatic test_param;
        logic [33:0] exp2 [6] = '{{16'hBEEF, 1'b1, 16'h0, 1'b0}, {16'h0, 1'b1, 16'h0, 1'b0},
                                  {16'h0, 1'b0, 16'h0, 1'b0}, {16'h0, 1'b1, 16'h0, 1'b0},
                                  {16'h0, 1'b1, 16'h0, 1'b0}, {16'h0, 1'b0, 16'h0, 1'b1}};
        req2 = 1; addr2 = 16'hBEEF;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            req2 = 0;
            checks++;
            if ({bus_out2, strobe2, io_oe2, ready2} !== exp2[i] || busy2 !== 1'b1) begin
                errors++;
                $display("FAIL param cyc%0d: got bus=%h stb=%b oe=%h rdy=%b busy=%b want %h",
                         i + 1, bus_out2, strobe2, io_oe2, ready2, busy2, exp2[i]);
            end
            io_in2 = i == 3 ? 16'h5678 : i == 4 ? 16'h1234 : 16'($urandom);
        end
        checks++;
        if (rdata2 !== 32'h12345678) begin
            errors++;
            $display("FAIL param_rdata: got %h want 12345678", rdata2);
        end
        @(posedge clk); #1;
        checks++;
        if (busy2 !== 1'b0) begin
            errors++;
            $display("FAIL param_idle: got busy=%b want 0", busy2);
        end
    endtask

    initial begin
        test_reset;
        test_write;
        test_read;
        test_back_to_back;
        test_wait;
        test_random;
        test_reset_mid_write;
        test_param;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cpu_bus_serdes.md
Name: cpu_bus_serdes

Overview:
- Parametrised bridge between the core's parallel memory port and the narrow pad-level bus.
- Each CPU access is serialised into an address phase, a command beat and a data phase.
- Data beats use a bidirectional lane; reads are deserialised back into a full word.
- Handshakes with the core through a request/ready pair instead of a fixed free-running phase count.

Parameters:
- ADDR_W, 32, CPU address width; must be a multiple of LANE_W.
- DATA_W, 32, CPU data width; must be a multiple of LANE_W.
- LANE_W, 8, pad lane width.
- Derived: ADDR_BEATS = ADDR_W/LANE_W and DATA_BEATS = DATA_W/LANE_W.
- A non-multiple width is a generate-time $error.

Ports:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cpu_req  in  1  access request; sampled only in IDLE
- cpu_we  in  1  1=write, 0=read; latched with cpu_req
- cpu_addr  in  ADDR_W  access address; latched with cpu_req
- cpu_wdata  in  DATA_W  write data; latched with cpu_req
- cpu_rdata  out  DATA_W  read data; held until the next read completes
- cpu_ready  out  1  one-cycle completion pulse
- busy  out  1  high in every state except IDLE
- bus_out  out  LANE_W  address/command lane
- bus_strobe  out  1  high on every valid address, command or data beat
- io_out  out  LANE_W  write-data lane
- io_in  in  LANE_W  read-data lane
- io_oe  out  LANE_W  lane enable; all-ones drives, all-zeros receives
- ext_wait  in  1  target stall; see Optional Feature

Behaviour:
- Reset: rst_n low forces the following immediately, including mid-transaction:
  - state to IDLE and beat counter to 0;
  - cpu_rdata, cpu_ready, busy, bus_out, bus_strobe, io_out and io_oe to 0.
  - No partial read data is kept.
- Outputs are Moore-style, a function of state and beat counter only; cpu_rdata is a register.
- States and transitions:
  - IDLE: if cpu_req=1, latch we, addr and wdata, then go to ADDR with beat 0.
  - ADDR: ADDR_BEATS cycles; bus_out = addr[beat], least significant lane first; bus_strobe=1; io_oe=0.
  - CMD: 1 cycle; bus_out = {zeros, we}; bus_strobe=1. Next state is WDATA if we=1, else TURN.
  - WDATA: DATA_BEATS cycles; io_oe all ones; io_out = wdata[beat], LSB lane first; bus_out=0; bus_strobe=1.
  - TURN: 1 cycle; io_oe=0; bus_strobe=0; this is the bus turnaround.
  - RDATA: DATA_BEATS cycles; io_oe=0; bus_strobe=1; io_in is captured at the end of each beat into lane [beat] of a shadow word.
  - DONE: 1 cycle; cpu_ready=1; on reads, cpu_rdata is loaded from the shadow word when entering DONE. Next state is IDLE.
- Latency from the acceptance edge to the cpu_ready cycle, at defaults:
  - write = ADDR_BEATS+1+DATA_BEATS+1 = 10 cycles;
  - read = 11 cycles.
- cpu_req outside IDLE is ignored, including in DONE. A request held high starts the next access on the cycle after DONE.
- io_oe is never all-ones in the cycle immediately before or after a RDATA beat.
- The beat counter is clog2(max(ADDR_BEATS, DATA_BEATS)) bits wide, resets to 0 on every state change, and never wraps inside a phase.

Optional Feature:
- Macro: CPU_BUS_SERDES_WAIT_EN.
- Defined:
  - ext_wait=1 during a WDATA or RDATA beat holds state, beat counter and all outputs for that cycle.
  - An RDATA beat with wait active does not capture io_in.
  - Waits may be unbounded.
  - ext_wait is ignored in all other states.
- Undefined: ext_wait is ignored entirely, and latency is fixed as given in Behaviour.

Test Plan:
- Write, defaults: cpu_we=1, addr=0x12345678, wdata=0xCAFEBABE.
  - bus_out sequence 78,56,34,12,01; then io_out BE,BA,FE,CA with io_oe=FF.
  - cpu_ready pulses 10 cycles after acceptance.
- Read: addr=0x000000A5; the bench drives io_in 11,22,33,44 on the RDATA beats.
  - cpu_rdata = 0x44332211 at the cpu_ready cycle (11 cycles).
  - io_oe stays 00 from CMD through DONE.
- Back-to-back: cpu_req held high for two accesses.
  - The second access starts its ADDR beat exactly 1 cycle after DONE.
  - busy is low for exactly 1 cycle (IDLE) between the two accesses.
- Reset mid-write: rst_n dropped asynchronously at the second WDATA beat.
  - io_oe=00, busy=0 and bus_strobe=0 with no clock edge.
  - After release, a new read completes normally with correct data.
- Parameters ADDR_W=16, DATA_W=32, LANE_W=16:
  - read of addr 0xBEEF gives 1 address beat (BEEF), then CMD 0000.
  - io_in 5678,1234 gives cpu_rdata = 0x12345678 in 6 cycles.
- With CPU_BUS_SERDES_WAIT_EN, ext_wait=1 for 3 cycles on RDATA beat 1:
  - io_in captured only after the stall;
  - cpu_ready arrives at cycle 14;
  - without the macro the same stimulus completes at cycle 11.
